// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU control decode with a one-cycle valid/ready issue stage.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_aluop2,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic        in_alusrc,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_a,
    output logic [63:0] out_b,
    output logic [3:0]  out_aluop,
    output logic        out_branch,
    output logic        out_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  aluop;
        logic        branch;
        logic        illegal;
    } issue_t;

    issue_t dec;
    logic   in_fire;

    always_comb begin
        dec         = '0;
        dec.a       = in_rs1;
        dec.b       = in_alusrc ? in_imm : in_rs2;
        dec.aluop   = OP_ADD;
        dec.branch  = 1'b0;
        dec.illegal = 1'b0;
        case (in_aluop2)
            2'b00: dec.aluop = OP_ADD;
            2'b01: begin
                dec.aluop  = OP_SUB;
                dec.branch = 1'b1;
            end
            2'b10: begin
                case (in_funct3)
                    // Immediate forms have no subtract; bit 30 there belongs to the immediate.
                    3'b000:  dec.aluop = (in_funct7b5 && !in_alusrc) ? OP_SUB : OP_ADD;
                    3'b111:  dec.aluop = OP_AND;
                    3'b110:  dec.aluop = OP_OR;
                    3'b010:  dec.aluop = OP_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_fire = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
    issue_t     slot0;
    issue_t     slot1;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       ready_q;
    logic       pop;

    assign pop = (count != 2'd0) && out_ready;

    always_comb begin
        count_next = count + {1'b0, in_fire} - {1'b0, pop};
    end

    // ready_q tracks count < 2 one cycle ahead so in_ready never sees out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0   <= '0;
            slot1   <= '0;
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            case ({in_fire, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= dec;
                    else               slot1 <= dec;
                end
                2'b01: slot0 <= slot1;
                2'b11: begin
                    if (count == 2'd1) slot0 <= dec;
                    else begin
                        slot0 <= slot1;
                        slot1 <= dec;
                    end
                end
                default: ;
            endcase
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
        end
    end

    assign in_ready    = ready_q && !reset;
    assign out_valid   = (count != 2'd0);
    assign out_a       = slot0.a;
    assign out_b       = slot0.b;
    assign out_aluop   = slot0.aluop;
    assign out_branch  = slot0.branch;
    assign out_illegal = slot0.illegal;
`else
    issue_t out_q;
    logic   valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (in_fire) begin
            out_q   <= dec;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready    = !reset && (!valid_q || out_ready);
    assign out_valid   = valid_q;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_aluop   = out_q.aluop;
    assign out_branch  = out_q.branch;
    assign out_illegal = out_q.illegal;
`endif

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 64 bits.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 in_valid  input  1  Upstream decode holds a valid instruction.
REQ-005 in_ready  output  1  Block accepts the instruction this cycle.
REQ-006 in_aluop2  input  2  Main-control class: 00 load/store, 01 branch, 10 R/I arithmetic, 11 reserved.
REQ-007 in_funct3  input  3  Instruction funct3.
REQ-008 in_funct7b5  input  1  Instruction bit 30.
REQ-009 in_alusrc  input  1  1 means operand b comes from the immediate.
REQ-010 in_rs1  input  64  Register source 1 data.
REQ-011 in_rs2  input  64  Register source 2 data.
REQ-012 in_imm  input  64  Sign-extended immediate.
REQ-013 out_valid  output  1  Issued ALU operation is valid.
REQ-014 out_ready  input  1  Execute stage consumes the operation.
REQ-015 out_a  output  64  ALU operand a.
REQ-016 out_b  output  64  ALU operand b.
REQ-017 out_aluop  output  4  ALU operation code.
REQ-018 out_branch  output  1  Operation is a branch compare; the consumer uses the ALU zero flag.
REQ-019 out_illegal  output  1  Unsupported encoding was decoded.

Function
REQ-020 A transfer SHALL occur on an input when in_valid and in_ready are both high, and on an output when out_valid and out_ready are both high.
REQ-021 Decode SHALL map: aluop2 00 -> 0010 (add); aluop2 01 -> 0110 (sub) with out_branch=1.
REQ-022 For aluop2 10, decode SHALL map: funct3 000 -> 0110 if funct7b5=1 and alusrc=0, else 0010; funct3 111 -> 0000 (AND); funct3 110 -> 0001 (OR); funct3 010 -> 1000 (set-less-than compare).
REQ-023 Any other aluop2 10 funct3 value, and any aluop2 11 encoding, SHALL issue 0010 with out_illegal=1.
REQ-024 Code 1100 (NOR) SHALL never be generated.
REQ-025 out_a SHALL equal in_rs1, and out_b SHALL equal in_imm when alusrc=1 and in_rs2 otherwise, all captured at the input transfer.
REQ-026 Latency SHALL be one cycle: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1 when the output is empty or drained.
REQ-027 Once out_valid=1, all out_* signals SHALL hold stable until the output transfer.
REQ-028 Ordering SHALL be strict FIFO, with no drop and no duplication.
REQ-029 Simultaneous input and output transfer while full SHALL sustain one instruction per cycle with no bubble.

Reset
REQ-030 Reset SHALL clear out_valid, out_branch and out_illegal to 0, out_aluop to 0000, out_a and out_b to 0, and empty all buffer entries.
REQ-031 in_ready SHALL be 0 during reset and 1 in the first cycle after reset deasserts.
REQ-032 Reset mid-transfer SHALL discard all held instructions; the execute stage sees no transfer on the cycle after reset.

Configuration
REQ-033 With ALU_ISSUE_SKID_EN defined, the block SHALL use a 2-entry skid buffer.
REQ-034 In that mode, in_ready SHALL be a registered signal equal to "fewer than 2 entries held".
REQ-035 In that mode, in_ready SHALL NOT depend combinationally on out_ready.
REQ-036 Without ALU_ISSUE_SKID_EN, the block SHALL use a single output register with in_ready = !out_valid || out_ready.
REQ-037 Decode and ordering behaviour SHALL be identical in both modes.

Verification
REQ-038 Scenario: aluop2=10, funct3=000, funct7b5=1, alusrc=0, rs1=10, rs2=3 -> next cycle out_aluop=0110, out_a=10, out_b=3, out_illegal=0.
REQ-039 Scenario: aluop2=10, funct3=000, funct7b5=1, alusrc=1, imm=-1 -> out_aluop=0010, out_b=0xFFFF_FFFF_FFFF_FFFF.
REQ-040 Scenario: aluop2=01 -> out_aluop=0110 and out_branch=1; aluop2=10, funct3=001 -> out_aluop=0010 and out_illegal=1.
REQ-041 Scenario: out_ready=0 for 5 cycles while 4 instructions are offered -> skid mode holds 2 and deasserts in_ready; non-skid mode holds 1; after out_ready=1, order is preserved with no loss.
REQ-042 Scenario: out_ready=1 continuously with a back-to-back input stream of 8 ops -> 8 output transfers in 8 consecutive cycles.
REQ-043 Scenario: reset asserted while 2 entries are held -> out_valid=0 next cycle, in_ready=1 after deassert, stale ops never appear.
